// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: round-robin arbiter sharing one valid/ready channel, with burst lock until the last beat
module rr_priority_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq-1:0]           req_last_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        gnt_valid_o,
  output logic                        gnt_last_o,
  output logic [DataWidth-1:0]        gnt_data_o,
  output logic [IdWidth-1:0]          gnt_id_o,
  input  logic                        gnt_ready_i
);
  logic [NumReq-1:0] ptr_q, ptr_d, owner_q, owner_d, mask, pick;
  logic              lock_q, lock_d, xfer;

  function automatic logic [NumReq-1:0] ffs(input logic [NumReq-1:0] x);
    return x & ~(x - NumReq'(1));
  endfunction

  // pick is forced to zero during reset so every output reads zero
  always_comb begin
    mask        = req_valid_i & ~(ptr_q - NumReq'(1));
    pick        = !rst_ni ? '0 : lock_q ? owner_q : (|mask) ? ffs(mask) : ffs(req_valid_i);
    gnt_data_o  = '0;
    gnt_id_o    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (pick[i]) begin
        gnt_data_o = gnt_data_o | req_data_i[i*DataWidth +: DataWidth];
        gnt_id_o   = gnt_id_o | IdWidth'(i);
      end
    end
    gnt_last_o  = |(pick & req_last_i);
    gnt_valid_o = |(pick & req_valid_i);
    req_ready_o = pick & req_valid_i & {NumReq{gnt_ready_i}};
    xfer        = gnt_valid_o & gnt_ready_i;
    ptr_d       = (xfer && gnt_last_o) ? ((pick << 1) | (pick >> (NumReq - 1))) : ptr_q;
    lock_d      = xfer ? !gnt_last_o : lock_q;
    owner_d     = xfer ? (gnt_last_o ? '0 : pick) : owner_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= NumReq'(1);
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: directed and random checks against a round-robin search model
module tb_rr_priority_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            gnt_valid_o, gnt_last_o;
  logic            gnt_ready_i = 1'b0;
  logic [DW-1:0]   gnt_data_o;
  logic [IW-1:0]   gnt_id_o;

  int vectors = 0;
  int errors  = 0;
  int ptr_m   = 0;
  int owner_m = 0;
  bit lock_m  = 0;

  always #5 clk_i = ~clk_i;

  rr_priority_arbiter #(.NumReq(N), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .gnt_valid_o(gnt_valid_o), .gnt_last_o(gnt_last_o),
    .gnt_data_o(gnt_data_o), .gnt_id_o(gnt_id_o), .gnt_ready_i(gnt_ready_i)
  );

  // owner when locked, otherwise first valid requester searching upward from ptr_m
  function automatic int pick_m();
    if (lock_m) return owner_m;
    for (int k = 0; k < N; k++)
      if (req_valid_i[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check(string tag);
    int p;
    logic v;
    logic [N-1:0] rdy;
    #1;
    p   = pick_m();
    v   = rst_ni && p >= 0 && req_valid_i[p];
    rdy = '0;
    if (v && gnt_ready_i) rdy[p] = 1'b1;
    cmp({tag, "_valid"}, gnt_valid_o, v);
    cmp({tag, "_ready"}, req_ready_o, rdy);
    cmp({tag, "_data"}, gnt_data_o, (rst_ni && p >= 0) ? req_data_i[p*DW +: DW] : '0);
    cmp({tag, "_last"}, gnt_last_o, (rst_ni && p >= 0) ? req_last_i[p] : 1'b0);
    cmp({tag, "_id"}, gnt_id_o, (rst_ni && p >= 0) ? p : 0);
  endtask

  task automatic cycle(string tag, output int xp);
    int p;
    check(tag);
    p  = pick_m();
    xp = (rst_ni && p >= 0 && req_valid_i[p] && gnt_ready_i) ? p : -1;
    @(posedge clk_i);
    if (xp >= 0) begin
      if (req_last_i[xp]) begin
        lock_m = 0;
        ptr_m  = (xp + 1) % N;
      end else begin
        lock_m  = 1;
        owner_m = xp;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    int xp, beats;
    int bl[N];
    for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = $urandom;
    req_valid_i = '1;
    req_last_i  = '1;
    gnt_ready_i = 1'b1;
    check("reset_t0");
    @(negedge clk_i);
    cycle("reset", xp);
    cycle("reset", xp);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 cmp("fair_id", gnt_id_o, i % 4);
      cmp("fair_onehot", req_ready_o, 1 << (i % 4));
      cycle("fair", xp);
    end
    for (int i = 0; i < 3; i++) cycle("pre_wrap", xp);
    req_valid_i = 4'b0010;
    #1 cmp("wrap_skip_id", gnt_id_o, 1);
    cycle("wrap_skip", xp);
    req_valid_i = 4'b0011;
    #1 cmp("wrap0_id", gnt_id_o, 0);
    cycle("wrap0", xp);
    #1 cmp("wrap1_id", gnt_id_o, 1);
    cycle("wrap1", xp);
    req_valid_i = 4'b0101;
    req_last_i  = 4'b0001;
    beats = 0;
    for (int c = 0; c < 12 && beats < 3; c++) begin
      gnt_ready_i   = ~c[0];
      req_last_i[2] = (beats == 2);
      #1 cmp("burst_id", gnt_id_o, 2);
      cycle("burst", xp);
      if (xp == 2) begin
        beats++;
        req_data_i[2*DW +: DW] = $urandom;
      end
    end
    cmp("burst_beats", beats, 3);
    req_valid_i[2] = 1'b0;
    gnt_ready_i    = 1'b1;
    #1 cmp("after_burst_id", gnt_id_o, 0);
    cycle("after_burst", xp);
    req_valid_i = 4'b1010;
    req_last_i  = '1;
    gnt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 cmp("bp_ready", req_ready_o, 0);
      cmp("bp_data", gnt_data_o, req_data_i[DW +: DW]);
      cycle("bp", xp);
    end
    gnt_ready_i = 1'b1;
    #1 cmp("bp_release_id", gnt_id_o, 1);
    cycle("bp_release", xp);
    req_valid_i = 4'b1000;
    req_last_i  = '0;
    cycle("rst_beat1", xp);
    req_data_i[3*DW +: DW] = $urandom;
    #2 rst_ni = 1'b0;
    ptr_m  = 0;
    lock_m = 0;
    #1 cmp("rst_mid_valid", gnt_valid_o, 0);
    cmp("rst_mid_ready", req_ready_o, 0);
    check("rst_mid");
    @(negedge clk_i);
    rst_ni      = 1'b1;
    req_valid_i = '1;
    req_last_i  = '1;
    #1 cmp("post_rst_id", gnt_id_o, 0);
    cycle("post_rst", xp);
    req_valid_i = 4'b0100;
    req_last_i  = '0;
    cycle("drop_b1", xp);
    req_valid_i = 4'b0001;
    req_last_i  = 4'b0001;
    #1 cmp("drop_valid", gnt_valid_o, 0);
    cmp("drop_id", gnt_id_o, 2);
    cycle("drop", xp);
    req_valid_i = 4'b0101;
    req_last_i  = 4'b0101;
    cycle("drop_end", xp);
    req_valid_i = '0;
    for (int i = 0; i < N; i++) bl[i] = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i] && $urandom_range(0, 2) == 0) begin
          req_valid_i[i]         = 1'b1;
          bl[i]                  = $urandom_range(1, 3);
          req_data_i[i*DW +: DW] = $urandom;
          req_last_i[i]          = (bl[i] == 1);
        end
      end
      gnt_ready_i = ($urandom_range(0, 3) != 0);
      cycle("rand", xp);
      if (xp >= 0) begin
        bl[xp]--;
        if (bl[xp] == 0) req_valid_i[xp] = 1'b0;
        else begin
          req_data_i[xp*DW +: DW] = $urandom;
          req_last_i[xp]          = (bl[xp] == 1);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
